// File: rtl/seq_calc.sv
// Multi-cycle unsigned arithmetic unit: single-cycle add/sub, WIDTH-cycle
// shift-add multiply and restoring divide under a start/done handshake.
module seq_calc #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               flag
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [WIDTH-1:0]   hi, hi_n;
  logic [WIDTH-1:0]   lo, lo_n;
  logic [WIDTH-1:0]   bq, bq_n;
  logic               is_div, is_div_n;
  logic               busy_n, done_n, flag_n;
  logic [2*WIDTH-1:0] result_n;

  logic [WIDTH:0]     addsum, subdiff, mulsum, divsh;
  logic [WIDTH+1:0]   divdiff;
  logic [WIDTH-1:0]   step_hi, step_lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      bq     <= '0;
      is_div <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      flag   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      hi     <= hi_n;
      lo     <= lo_n;
      bq     <= bq_n;
      is_div <= is_div_n;
      busy   <= busy_n;
      done   <= done_n;
      result <= result_n;
      flag   <= flag_n;
    end
  end

  always_comb begin
    addsum  = {1'b0, a} + {1'b0, b};
    subdiff = {1'b0, a} - {1'b0, b};

    // Multiply: hi is the upper partial product, lo the shifting multiplier.
    mulsum  = {1'b0, hi} + (lo[0] ? {1'b0, bq} : '0);
    // Divide: hi is the partial remainder, lo the dividend becoming the quotient.
    divsh   = {hi, lo[WIDTH-1]};
    divdiff = {1'b0, divsh} - {2'b0, bq};

    if (is_div) begin
      if (!divdiff[WIDTH+1]) begin
        step_hi = divdiff[WIDTH-1:0];
        step_lo = {lo[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = divsh[WIDTH-1:0];
        step_lo = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi = mulsum[WIDTH:1];
      step_lo = {mulsum[0], lo[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    hi_n     = hi;
    lo_n     = lo;
    bq_n     = bq;
    is_div_n = is_div;
    busy_n   = busy;
    done_n   = 1'b0;
    result_n = result;
    flag_n   = flag;

    unique case (state)
      IDLE: begin
        if (start) begin
          unique case (op)
            2'b00: begin
              done_n   = 1'b1;
              result_n = {{WIDTH{1'b0}}, addsum[WIDTH-1:0]};
              flag_n   = addsum[WIDTH];
            end
            2'b01: begin
              done_n   = 1'b1;
              result_n = {{WIDTH{1'b0}}, subdiff[WIDTH-1:0]};
              flag_n   = subdiff[WIDTH];
            end
            default: begin
              if (op[0] && (b == '0)) begin
                done_n   = 1'b1;
                result_n = {a, {WIDTH{1'b1}}};
                flag_n   = 1'b1;
              end else begin
                state_n  = RUN;
                cnt_n    = CW'(WIDTH);
                hi_n     = '0;
                lo_n     = a;
                bq_n     = b;
                is_div_n = op[0];
                busy_n   = 1'b1;
              end
            end
          endcase
        end
      end
      RUN: begin
        hi_n  = step_hi;
        lo_n  = step_lo;
        cnt_n = cnt - 1'b1;
        // Result is taken from this final iteration, not the stale registers.
        if (cnt == CW'(1)) begin
          state_n  = IDLE;
          busy_n   = 1'b0;
          done_n   = 1'b1;
          result_n = {step_hi, step_lo};
          flag_n   = is_div ? 1'b0 : (step_hi != '0);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_calc.sv
// Directed self-checking bench for seq_calc at WIDTH=8 with hand-computed results.
module tb_seq_calc;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [1:0]     op;
  logic [W-1:0]   a, b;
  logic           busy, done, flag;
  logic [2*W-1:0] result;

  int unsigned vecs = 0;
  int unsigned errs = 0;

  seq_calc #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .flag   (flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single-cycle op: done and the result appear after the sampling edge.
  task automatic op1(input logic [1:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb,
                     input logic [15:0] exp_res, input logic exp_flag);
    @(negedge clk);
    start = 1'b1; op = o; a = xa; b = xb;
    tick();
    check("op1_done", done, 1);
    check("op1_busy", busy, 0);
    check("op1_result", result, exp_res);
    check("op1_flag", flag, exp_flag);
  endtask

  task automatic idle_check();
    @(negedge clk);
    start = 1'b0;
    tick();
    check("idle_done", done, 0);
  endtask

  // Multi-cycle op; optionally scrambles inputs or pulses a spurious add start mid-run.
  task automatic multi(input logic [1:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb,
                       input logic [15:0] exp_res, input logic exp_flag,
                       input bit scramble, input bit inject);
    @(negedge clk);
    start = 1'b1; op = o; a = xa; b = xb;
    tick();
    check("acc_busy", busy, 1);
    check("acc_done", done, 0);
    for (int i = 1; i <= W; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (scramble) begin
        a  = W'($urandom);
        b  = W'($urandom);
        op = 2'($urandom);
      end
      if (inject && i == 3) begin
        start = 1'b1; op = 2'b00; a = 8'd1; b = 8'd1;
      end
      tick();
      if (i < W) begin
        check("run_busy", busy, 1);
        check("run_done", done, 0);
      end else begin
        check("fin_done", done, 1);
        check("fin_busy", busy, 0);
        check("fin_result", result, exp_res);
        check("fin_flag", flag, exp_flag);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b1; op = 2'($urandom); a = W'($urandom); b = W'($urandom);
    tick();
    start = 1'($urandom); op = 2'($urandom); a = W'($urandom); b = W'($urandom);
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 16'h0000);
    check("rst_flag", flag, 0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;

    // add then back-to-back subs: done stays high with each new result
    op1(2'b00, 8'd200, 8'd100, 16'h002C, 1'b1);
    op1(2'b01, 8'd5, 8'd7, 16'h00FE, 1'b1);
    op1(2'b01, 8'd7, 8'd5, 16'h0002, 1'b0);
    idle_check();
    check("hold_result", result, 16'h0002);

    multi(2'b10, 8'd15, 8'd17, 16'h00FF, 1'b0, 1'b0, 1'b0);
    idle_check();
    multi(2'b10, 8'd255, 8'd255, 16'hFE01, 1'b1, 1'b0, 1'b0);
    idle_check();
    multi(2'b10, 8'd15, 8'd17, 16'h00FF, 1'b0, 1'b1, 1'b0);
    idle_check();
    multi(2'b10, 8'd200, 8'd3, 16'h0258, 1'b1, 1'b0, 1'b1);
    idle_check();

    multi(2'b11, 8'd100, 8'd7, 16'h020E, 1'b0, 1'b0, 1'b0);
    idle_check();
    multi(2'b11, 8'd255, 8'd16, 16'h0F0F, 1'b0, 1'b1, 1'b0);
    idle_check();
    op1(2'b11, 8'd9, 8'd0, 16'h09FF, 1'b1);
    idle_check();
    check("dz_busy", busy, 0);

    // new mul accepted in the done cycle of the previous one
    multi(2'b10, 8'd3, 8'd4, 16'h000C, 1'b0, 1'b0, 1'b0);
    multi(2'b10, 8'd6, 8'd7, 16'h002A, 1'b0, 1'b0, 1'b0);
    idle_check();

    // reset during the 4th cycle of a divide
    @(negedge clk);
    start = 1'b1; op = 2'b11; a = 8'd100; b = 8'd7;
    tick();
    check("rdiv_busy", busy, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      tick();
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 16'h0000);
    check("abort_flag", flag, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      tick();
      check("abort_nodone", done, 0);
    end
    op1(2'b00, 8'd1, 8'd1, 16'h0002, 1'b0);
    idle_check();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
